// File: rtl/sync_debounce.sv
// sync_debounce: per-channel N-flop synchronizer, stability-counter debouncer
// and registered rise/fall strobes for asynchronous board inputs.
// Optional build macro: SYNC_DEBOUNCE_EDGE_EN enables the rise/fall strobe
// flops; without it rise and fall are tied to 0 and q timing is unchanged.
module sync_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned STAGES          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter logic        INIT            = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values that cannot synchronize or debounce.
  if (STAGES < 2) begin : g_bad_stages
    $error("sync_debounce: STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("sync_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0][STAGES-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]             q_q, q_d;
  logic [WIDTH-1:0]             ys_c;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;
`endif

  // Next-state: shift the sync chains, run the stability counters, accept new levels.
  always_comb begin
    sync_d = sync_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    ys_c   = '0;
`ifdef SYNC_DEBOUNCE_EDGE_EN
    rise_d = '0;
    fall_d = '0;
`endif
    for (int i = 0; i < int'(WIDTH); i++) begin
      // Only s[1] samples s[0]; d enters the design solely through s[0].
      sync_d[i] = {sync_q[i][STAGES-2:0], d[i]};
      ys_c[i]   = sync_q[i][STAGES-1];
      if (ys_c[i] == q_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        q_d[i]   = ys_c[i];
        cnt_d[i] = '0;
`ifdef SYNC_DEBOUNCE_EDGE_EN
        rise_d[i] = ys_c[i];
        fall_d[i] = ~ys_c[i];
`endif
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State registers; reset discards any partial count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {(WIDTH * STAGES){INIT}};
      cnt_q  <= '0;
      q_q    <= {WIDTH{INIT}};
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
    end
  end

`ifdef SYNC_DEBOUNCE_EDGE_EN
  // Edge strobe registers, one cycle wide and coincident with the q update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = '0;
  assign fall = '0;
`endif

  assign q = q_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Directed self-checking bench for sync_debounce: default 4-channel instance
// plus a 1-channel STAGES=3 / DEBOUNCE_CYCLES=1 instance.
`timescale 1ns / 1ps
module tb_sync_debounce;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] d;
  logic [3:0] q, rise, fall;
  logic [0:0] d2;
  logic [0:0] q2, rise2, fall2;

  int checks = 0;
  int errors = 0;

  sync_debounce u_dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (q),
    .rise (rise),
    .fall (fall)
  );

  sync_debounce #(
    .WIDTH          (1),
    .STAGES         (3),
    .DEBOUNCE_CYCLES(1)
  ) u_dut2 (
    .clk  (clk),
    .reset(reset),
    .d    (d2),
    .q    (q2),
    .rise (rise2),
    .fall (fall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one posedge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] en4(input logic [3:0] v);
    return EDGE_EN ? v : 4'b0000;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    d     = 4'hF;
    d2    = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      d = ~d;
      checks++;
      if (q !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || q2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d q=%b rise=%b fall=%b q2=%b want 0", n, q, rise, fall, q2);
      end
    end
    d = 4'h0;
    tick();
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (q !== 4'h0 || rise !== 4'h0 || fall !== 4'h0 || q2 !== 1'b0 || rise2 !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc %0d q=%b rise=%b fall=%b q2=%b want 0", n, q, rise, fall, q2);
      end
    end
  endtask

  task automatic test_clean_edge();
    d = 4'b0001;
    for (int n = 1; n <= 7; n++) begin
      logic [3:0] eq, er;
      tick();
      eq = (n >= 6) ? 4'b0001 : 4'b0000;
      er = (n == 6) ? en4(4'b0001) : 4'b0000;
      checks++;
      if (q !== eq || rise !== er || fall !== 4'b0000) begin
        errors++;
        $display("FAIL clean_edge edge %0d q=%b rise=%b fall=%b want q=%b rise=%b fall=0000",
                 n, q, rise, fall, eq, er);
      end
    end
  endtask

  task automatic test_glitch();
    d = 4'b0011;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 3) d = 4'b0001;
      checks++;
      if (q !== 4'b0001 || rise !== 4'b0000 || fall !== 4'b0000) begin
        errors++;
        $display("FAIL glitch3 cyc %0d q=%b rise=%b fall=%b want q=0001 rise=0000 fall=0000",
                 n, q, rise, fall);
      end
    end
    d = 4'b0011;
    for (int n = 1; n <= 12; n++) begin
      logic [3:0] eq, er, ef;
      tick();
      if (n == 4) d = 4'b0001;
      eq = (n >= 6 && n <= 9) ? 4'b0011 : 4'b0001;
      er = (n == 6) ? en4(4'b0010) : 4'b0000;
      ef = (n == 10) ? en4(4'b0010) : 4'b0000;
      checks++;
      if (q !== eq || rise !== er || fall !== ef) begin
        errors++;
        $display("FAIL glitch4 cyc %0d q=%b rise=%b fall=%b want q=%b rise=%b fall=%b",
                 n, q, rise, fall, eq, er, ef);
      end
    end
  endtask

  task automatic test_fall_indep();
    d = 4'hF;
    for (int n = 1; n <= 7; n++) tick();
    checks++;
    if (q !== 4'hF) begin
      errors++;
      $display("FAIL fall_setup q=%b want 1111", q);
    end
    d = 4'b1010;
    for (int n = 1; n <= 8; n++) begin
      logic [3:0] eq, ef;
      tick();
      eq = (n >= 6) ? 4'b1010 : 4'b1111;
      ef = (n == 6) ? en4(4'b0101) : 4'b0000;
      checks++;
      if (q !== eq || fall !== ef || rise !== 4'b0000) begin
        errors++;
        $display("FAIL fall_indep edge %0d q=%b rise=%b fall=%b want q=%b rise=0000 fall=%b",
                 n, q, rise, fall, eq, ef);
      end
    end
  endtask

  task automatic test_reset_mid();
    d = 4'b1110;
    for (int n = 1; n <= 4; n++) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async q=%b rise=%b fall=%b want 0", q, rise, fall);
    end
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if (q !== 4'b0000 || rise !== 4'b0000 || fall !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_hold cyc %0d q=%b rise=%b fall=%b want 0", n, q, rise, fall);
      end
    end
    reset = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      logic [3:0] eq, er;
      tick();
      eq = (n >= 6) ? 4'b1110 : 4'b0000;
      er = (n == 6) ? en4(4'b1110) : 4'b0000;
      checks++;
      if (q !== eq || rise !== er || fall !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_requal edge %0d q=%b rise=%b fall=%b want q=%b rise=%b fall=0000",
                 n, q, rise, fall, eq, er);
      end
    end
  endtask

  task automatic test_param_sweep();
    d2 = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      logic eq, er;
      tick();
      eq = (n >= 4);
      er = (n == 4) && EDGE_EN;
      checks++;
      if (q2 !== eq || rise2 !== er || fall2 !== 1'b0) begin
        errors++;
        $display("FAIL sweep edge %0d q2=%b rise2=%b fall2=%b want q2=%b rise2=%b fall2=0",
                 n, q2, rise2, fall2, eq, er);
      end
    end
    d2 = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      logic eq, ef;
      tick();
      eq = (n < 4);
      ef = (n == 4) && EDGE_EN;
      checks++;
      if (q2 !== eq || fall2 !== ef || rise2 !== 1'b0) begin
        errors++;
        $display("FAIL sweep_fall edge %0d q2=%b rise2=%b fall2=%b want q2=%b rise2=0 fall2=%b",
                 n, q2, rise2, fall2, eq, ef);
      end
    end
  endtask

  // Pulses on the same channel must never overlap.
  always @(negedge clk) begin
    if (reset === 1'b1 && ((rise & fall) !== 4'b0000)) begin
      $display("FAIL rise_fall_overlap rise=%b fall=%b want disjoint", rise, fall);
    end
  end

  initial begin
    reset = 1'b0;
    d     = 4'h0;
    d2    = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_fall_indep();
    test_reset_mid();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Parametrised multi-channel input conditioner: N-flop synchronizer per channel, then a per-channel stability counter (debouncer), then registered rise/fall pulse generation.
- Successor to the fixed 1-bit, 2-flop `sync`.
- Sits between asynchronous board inputs (keypad rows/cols, buttons) and the keypad scanner / control FSMs.
- Consumers get clean levels plus single-cycle edge strobes.

Parameters:
- WIDTH, 4, number of independent channels.
- STAGES, 2, synchronizer flops per channel; must be >= 2, elaboration error otherwise.
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized value must differ from the output before it is accepted; must be >= 1, elaboration error otherwise.
- INIT, 0, reset value of every sync flop and of q (1-bit, applied to all channels).

Ports:
- clk  input  1  system clock; all flops posedge.
- reset  input  1  asynchronous, active-low reset.
- d  input  WIDTH  asynchronous raw inputs.
- q  output  WIDTH  synchronized, debounced level.
- rise  output  WIDTH  1-cycle pulse when q[i] goes 0->1.
- fall  output  WIDTH  1-cycle pulse when q[i] goes 1->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - all sync flops = INIT, q = {WIDTH{INIT}}
  - all counters = 0, rise = 0, fall = 0
- Release of reset produces no pulses.
- Channels are fully independent; no cross-channel interaction.
- Sync chain per channel: s[0] <= d[i]; s[k] <= s[k-1]. Call the synchronized value `ys = s[STAGES-1]`. d is never used combinationally.
- Counter per channel: width $clog2(DEBOUNCE_CYCLES+1). Each posedge, in priority order:
  - ys == q[i]: cnt <= 0; rise/fall <= 0.
  - ys != q[i] and cnt == DEBOUNCE_CYCLES-1: q[i] <= ys; cnt <= 0; rise[i] <= ys; fall[i] <= ~ys.
  - otherwise: cnt <= cnt + 1; rise/fall <= 0.
- Latency: d changes between edges and is held stable. q, and the matching pulse, update on the (STAGES + DEBOUNCE_CYCLES)-th following posedge. Defaults: 6 edges.
- Glitch rejection: any excursion whose synchronized form is shorter than DEBOUNCE_CYCLES cycles returns the counter to 0 and leaves q unchanged.
- Pulses: registered, exactly one cycle wide, coincident with the q update. rise and fall are never both 1 on the same channel.
- Counter never wraps; max value is DEBOUNCE_CYCLES-1.
- Simultaneous changes on several channels update in the same cycle if their timing is identical.
- Reset asserted mid-count: everything returns to reset values immediately; a partial count is discarded.
- Metastability: only s[0] may go metastable; nothing but s[1] samples it.

Optional Feature:
- Macro: SYNC_DEBOUNCE_EDGE_EN.
- Defined: rise/fall behave as above.
- Undefined:
  - rise and fall are constant 0.
  - Their flops are not instantiated.
  - Ports remain present so instantiations do not change.
  - q timing is identical in both builds.

Test Plan:
- Reset: reset=0 with d=4'hF toggling, then release, INIT=0 -> q=0, rise=0, fall=0 for every cycle; no pulse on release.
- Clean edge, defaults: d[0] 0->1 2 ps after a posedge, held -> q[0]=1 and rise[0]=1 on the 6th posedge; rise[0]=0 on the 7th; q[0]=0 checked after posedges 1-5.
- Glitch rejection: d[1]=1 for 3 clock periods, then back to 0 -> q[1] stays 0, rise[1] never 1. A 4-period pulse on d[1] -> q[1] goes 1 for 4 cycles, then returns to 0 with rise then fall pulses.
- Falling edge and independence: q=4'b1111 stable, d=4'b1010 -> q=4'b1010 after 6 edges; fall=4'b0101 for exactly one cycle; rise=0.
- Reset mid-count: d[2] 0->1, reset=0 after 4 posedges, released 3 cycles later with d held 1 -> q[2] is 0 during reset and re-qualifies a full 6 edges after release.
- Parameter sweep: STAGES=3, DEBOUNCE_CYCLES=1, WIDTH=1; d 0->1 -> q=1 on the 4th posedge.
- Repeat one scenario with SYNC_DEBOUNCE_EDGE_EN undefined -> rise=fall=0 always, q timing unchanged.
